// File: rtl/crypt_pkg.sv
// Shared types and constants for the crypt stream controller.
//   state_t      : controller FSM states (NOKEY, ARMED, ZERO)
//   MODE_ENC/DEC : per-byte mode encoding
//   byte_t       : 8-bit data/key type
//   fifo_entry_t : output FIFO payload {mode, data}
package crypt_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        ARMED = 2'd1,
        ZERO  = 2'd2
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef struct packed {
        logic  mode;
        byte_t data;
    } fifo_entry_t;

endpackage

// File: rtl/crypt_stream_ctrl_if.sv
// Byte stream interface between host and crypt controller.
//   in_*  : host -> controller byte stream with per-byte mode
//   out_* : controller -> consumer processed bytes with the mode used
// master = host/consumer side, slave = controller side.
interface crypt_stream_ctrl_if;
    import crypt_pkg::*;

    logic  in_valid;
    logic  in_ready;
    byte_t in_data;
    logic  in_mode;
    logic  out_valid;
    logic  out_ready;
    byte_t out_data;
    logic  out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );

endinterface

// File: rtl/crypt_out_fifo.sv
// First-word fall-through output FIFO holding {mode, data} entries.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of all entries
//   push, push_data : write one entry
//   pop        : remove head entry (ignored when empty)
//   head_valid, head_data : current head entry
//   count      : number of stored entries
module crypt_out_fifo
    import crypt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  fifo_entry_t                 push_data,
    input  logic                        pop,
    output logic                        head_valid,
    output fifo_entry_t                 head_data,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    fifo_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [FILL_W-1:0] count_next;

    // Push into a full FIFO is only accepted alongside a pop.
    always_comb begin
        do_pop     = pop & (count != '0);
        do_push    = push & ((count != FILL_W'(FIFO_DEPTH)) | do_pop);
        count_next = count + FILL_W'(do_push) - FILL_W'(do_pop);
    end

    // Storage, pointers (wrap by power-of-two width) and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_next;
            head_valid <= (count_next != '0);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/decrypt.sv
// Combinational 8-bit byte cipher, decrypt direction (inverse of encrypt).
//   key : session key
//   inp : ciphertext byte
//   out : plaintext byte, (inp - key) ^ key
module decrypt (
    input  logic [7:0] key,
    input  logic [7:0] inp,
    output logic [7:0] out
);

    assign out = (inp - key) ^ key;

endmodule

// File: rtl/encrypt.sv
// Combinational 8-bit byte cipher, encrypt direction.
//   key : session key
//   inp : plaintext byte
//   out : ciphertext byte, (inp ^ key) + key
module encrypt (
    input  logic [7:0] key,
    input  logic [7:0] inp,
    output logic [7:0] out
);

    assign out = (inp ^ key) + key;

endmodule

// File: rtl/crypt_stream_ctrl.sv
// Sequencer for the shared encrypt/decrypt cores: holds the session key,
// stages each accepted byte with a key snapshot, runs it through the
// selected core and buffers the result in a small FWFT FIFO.
//   clk, rst_n  : clock, async active-low reset
//   key_wr, key_in : key load strobe and value
//   zeroize     : wipes key, stage, FIFO and counter
//   bus         : in/out byte streams (slave side)
//   key_loaded  : high while ARMED
//   err_nokey   : pulse for each cycle a byte is offered while not ARMED
//   byte_count  : saturating count of delivered bytes
module crypt_stream_ctrl
    import crypt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_wr,
    input  byte_t               key_in,
    input  logic                zeroize,
    crypt_stream_ctrl_if.slave  bus,
    output logic                key_loaded,
    output logic                err_nokey,
    output logic [CNT_W-1:0]    byte_count
);

    localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    byte_t             key_q;
    logic              stage_valid;
    fifo_entry_t       stage_q;
    byte_t             stage_key;
    byte_t             enc_out;
    byte_t             dec_out;
    fifo_entry_t       result;
    logic              head_valid;
    fifo_entry_t       head_data;
    logic [FILL_W-1:0] fifo_count;
    logic              flush_c;
    logic              in_ready_c;
    logic              accept_c;
    logic              key_load_c;
    logic              err_c;
    logic              pop_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NOKEY;
        end else begin
            state <= state_next;
        end
    end

    // Next state; zeroize wins over key_wr.
    always_comb begin
        state_next = state;
        unique case (state)
            NOKEY: begin
                if (zeroize)     state_next = ZERO;
                else if (key_wr) state_next = ARMED;
            end
            ARMED: begin
                if (zeroize) state_next = ZERO;
            end
            ZERO:    state_next = NOKEY;
            default: state_next = NOKEY;
        endcase
    end

    // Control decode; stage occupancy counts against FIFO space so a
    // staged byte always has a slot to land in.
    always_comb begin
        flush_c    = zeroize | (state == ZERO);
        in_ready_c = (state == ARMED) & ~zeroize &
                     ((fifo_count + FILL_W'(stage_valid)) < FILL_W'(FIFO_DEPTH));
        accept_c   = bus.in_valid & in_ready_c;
        key_load_c = key_wr & ~flush_c;
        err_c      = bus.in_valid & (state != ARMED);
        pop_c      = bus.out_ready & head_valid;
    end

    // Key register and input stage; the stage captures the pre-update key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            stage_valid <= 1'b0;
            stage_q     <= '0;
            stage_key   <= '0;
        end else if (flush_c) begin
            key_q       <= '0;
            stage_valid <= 1'b0;
        end else begin
            if (key_load_c) begin
                key_q <= key_in;
            end
            stage_valid <= accept_c;
            if (accept_c) begin
                stage_q   <= '{mode: bus.in_mode, data: bus.in_data};
                stage_key <= key_q;
            end
        end
    end

    // Registered status outputs and delivered-byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_loaded <= 1'b0;
            err_nokey  <= 1'b0;
            byte_count <= '0;
        end else begin
            key_loaded <= (state_next == ARMED);
            err_nokey  <= err_c;
            if (flush_c) begin
                byte_count <= '0;
            end else if (pop_c && (byte_count != '1)) begin
                byte_count <= byte_count + CNT_W'(1);
            end
        end
    end

    encrypt u_encrypt (
        .key (stage_key),
        .inp (stage_q.data),
        .out (enc_out)
    );

    decrypt u_decrypt (
        .key (stage_key),
        .inp (stage_q.data),
        .out (dec_out)
    );

    assign result.mode = stage_q.mode;
    assign result.data = (stage_q.mode == MODE_DEC) ? dec_out : enc_out;

    crypt_out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_c),
        .push       (stage_valid),
        .push_data  (result),
        .pop        (pop_c),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_data.data;
    assign bus.out_mode  = head_data.mode;

endmodule

// File: tb/tb_crypt_stream_ctrl.sv
// Directed bench for crypt_stream_ctrl: vector table of {mode, input, expected
// output} applied through a valid/ready driver, plus hand sequences for
// backpressure, rekey, zeroize and asynchronous reset.
module tb_crypt_stream_ctrl;
    import crypt_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic       mode;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               key_wr;
    byte_t              key_in;
    logic               zeroize;
    logic               key_loaded;
    logic               err_nokey;
    logic [CNT_W-1:0]   byte_count;

    crypt_stream_ctrl_if bus ();

    crypt_stream_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_wr     (key_wr),
        .key_in     (key_in),
        .zeroize    (zeroize),
        .bus        (bus.slave),
        .key_loaded (key_loaded),
        .err_nokey  (err_nokey),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    vec_t       vt [19];
    int         errors = 0;
    int         checks = 0;
    int         exp_total = 0;
    int         cyc = 0;
    logic [8:0] got [$];
    int         acc_log [$];
    int         out_log [$];

    // Handshake monitor: records accepts and deliveries with cycle stamps.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_log.push_back(cyc);
            if (bus.out_valid && bus.out_ready) begin
                got.push_back({bus.out_mode, bus.out_data});
                out_log.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int t);
        int mx;
        mx = (1 << CNT_W) - 1;
        return (t > mx) ? mx : t;
    endfunction

    task automatic send_one(input int i);
        logic ok;
        int   c;
        ok = 1'b0;
        c  = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = vt[i].din;
        bus.in_mode  = vt[i].mode;
        while (!ok && c < 40) begin
            #1;
            ok = bus.in_ready;
            tick();
            c++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: vector %0d not accepted within 40 cycles", i);
        end
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_one(i);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for hi-lo+1 deliveries and compare them in order.
    task automatic expect_range(input string name, input int lo, input int hi);
        int n;
        int m;
        n = hi - lo + 1;
        for (int c = 0; c < 60 && got.size() < n; c++) tick();
        repeat (3) tick();
        check({name, "_count"}, 32'(got.size()), 32'(n));
        m = (got.size() < n) ? got.size() : n;
        for (int k = 0; k < m; k++) begin
            check($sformatf("%s[%0d]", name, k), 32'(got[k]),
                  32'({vt[lo+k].mode, vt[lo+k].exp}));
        end
        got.delete();
        exp_total += n;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),  32'(0));
        check({tag, "_out_valid"},  32'(bus.out_valid), 32'(0));
        check({tag, "_out_data"},   32'(bus.out_data),  32'(0));
        check({tag, "_out_mode"},   32'(bus.out_mode),  32'(0));
        check({tag, "_key_loaded"}, 32'(key_loaded),    32'(0));
        check({tag, "_err_nokey"},  32'(err_nokey),     32'(0));
        check({tag, "_byte_count"}, 32'(byte_count),    32'(0));
    endtask

    task automatic load_key(input logic [7:0] k);
        key_wr = 1'b1;
        key_in = k;
        tick();
        key_wr = 1'b0;
    endtask

    initial begin
        // Decrypt stream, key 0x3c: out = (in - 0x3c) ^ 0x3c
        vt[0]  = '{1'b1, 8'h86, 8'h76};
        vt[1]  = '{1'b1, 8'h1b, 8'he3};
        vt[2]  = '{1'b1, 8'h47, 8'h37};
        vt[3]  = '{1'b1, 8'h09, 8'hf1};
        vt[4]  = '{1'b1, 8'h26, 8'hd6};
        // Encrypt, key 0x3c: out = (in ^ 0x3c) + 0x3c
        vt[5]  = '{1'b0, 8'h00, 8'h78};
        vt[6]  = '{1'b0, 8'h5a, 8'ha2};
        vt[7]  = '{1'b0, 8'hff, 8'hff};
        // Round trip back to plaintext
        vt[8]  = '{1'b1, 8'h78, 8'h00};
        vt[9]  = '{1'b1, 8'ha2, 8'h5a};
        vt[10] = '{1'b1, 8'hff, 8'hff};
        // Backpressure stream, encrypt with 0x3c
        vt[11] = '{1'b0, 8'h01, 8'h79};
        vt[12] = '{1'b0, 8'h02, 8'h7a};
        vt[13] = '{1'b0, 8'h03, 8'h7b};
        vt[14] = '{1'b0, 8'h04, 8'h74};
        vt[15] = '{1'b0, 8'h05, 8'h75};
        vt[16] = '{1'b0, 8'h06, 8'h76};
        // Rekey: A with old key 0x3c, B with new key 0x55
        vt[17] = '{1'b0, 8'h10, 8'h68};
        vt[18] = '{1'b0, 8'h10, 8'h9a};

        key_wr        = 1'b0;
        key_in        = '0;
        zeroize       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // No key: bytes refused, one error pulse per offered cycle.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h86;
        bus.in_mode  = MODE_DEC;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("nokey_in_ready[%0d]", i), 32'(bus.in_ready), 32'(0));
            tick();
            check($sformatf("nokey_err[%0d]", i), 32'(err_nokey), 32'(1));
            check($sformatf("nokey_out_valid[%0d]", i), 32'(bus.out_valid), 32'(0));
        end
        bus.in_valid = 1'b0;
        tick();
        check("nokey_err_clear", 32'(err_nokey), 32'(0));

        load_key(8'h3c);
        check("armed_key_loaded", 32'(key_loaded), 32'(1));

        // Decrypt stream with 2-cycle first-byte latency.
        bus.out_ready = 1'b1;
        acc_log.delete();
        out_log.delete();
        send_range(0, 4);
        expect_range("dec", 0, 4);
        if (acc_log.size() > 0 && out_log.size() > 0)
            check("dec_latency", 32'(out_log[0] - acc_log[0]), 32'(2));
        else
            check("dec_latency_seen", 32'(out_log.size()), 32'(1));
        check("dec_byte_count", 32'(byte_count), 32'(sat(exp_total)));

        send_range(5, 7);
        expect_range("enc", 5, 7);
        send_range(8, 10);
        expect_range("rtrip", 8, 10);
        check("rtrip_byte_count", 32'(byte_count), 32'(sat(exp_total)));

        // Backpressure: only DEPTH bytes fit, head holds steady.
        bus.out_ready = 1'b0;
        acc_log.delete();
        fork
            send_range(11, 16);
            begin
                repeat (8) tick();
                check("bp_accepted", 32'(acc_log.size()), 32'(DEPTH));
                check("bp_in_ready", 32'(bus.in_ready), 32'(0));
                check("bp_out_valid", 32'(bus.out_valid), 32'(1));
                check("bp_head0", 32'(bus.out_data), 32'(8'h79));
                repeat (3) tick();
                check("bp_head1", 32'(bus.out_data), 32'(8'h79));
                check("bp_out_valid1", 32'(bus.out_valid), 32'(1));
                bus.out_ready = 1'b1;
            end
        join
        expect_range("bp", 11, 16);
        check("bp_byte_count_sat", 32'(byte_count), 32'(sat(exp_total)));

        // Rekey in the same cycle byte A is accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        bus.in_mode  = MODE_ENC;
        key_wr       = 1'b1;
        key_in       = 8'h55;
        #1;
        check("rekey_ready_a", 32'(bus.in_ready), 32'(1));
        tick();
        key_wr = 1'b0;
        #1;
        check("rekey_ready_b", 32'(bus.in_ready), 32'(1));
        tick();
        bus.in_valid = 1'b0;
        expect_range("rekey", 17, 18);

        // Zeroize with three bytes buffered.
        bus.out_ready = 1'b0;
        send_range(0, 2);
        repeat (2) tick();
        check("zero_pre_valid", 32'(bus.out_valid), 32'(1));
        check("zero_pre_count", 32'(byte_count), 32'(sat(exp_total)));
        zeroize = 1'b1;
        #1;
        check("zero_in_ready", 32'(bus.in_ready), 32'(0));
        tick();
        zeroize = 1'b0;
        exp_total = 0;
        check("zero_out_valid", 32'(bus.out_valid), 32'(0));
        check("zero_byte_count", 32'(byte_count), 32'(0));
        check("zero_key_loaded", 32'(key_loaded), 32'(0));
        key_wr = 1'b1;
        key_in = 8'h3c;
        #1;
        check("zero_state_ready", 32'(bus.in_ready), 32'(0));
        tick();
        key_wr = 1'b0;
        check("nokey_after_zero", 32'(key_loaded), 32'(0));
        check("nokey_after_zero_ready", 32'(bus.in_ready), 32'(0));
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("zero_no_delivery", 32'(got.size()), 32'(0));
        got.delete();

        // Restart, deliver, then reset asynchronously with bytes buffered.
        load_key(8'h3c);
        check("reload_key_loaded", 32'(key_loaded), 32'(1));
        send_range(5, 6);
        expect_range("post", 5, 6);
        check("post_byte_count", 32'(byte_count), 32'(sat(exp_total)));
        bus.out_ready = 1'b0;
        send_range(5, 6);
        tick();
        check("pre_rst_valid", 32'(bus.out_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_key_loaded", 32'(key_loaded), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
